// File: rtl/xc_aessub_multi.sv
// Multi-cycle AES SubBytes / InvSubBytes on four gathered bytes, one S-box
// evaluation per cycle through a single shared GF(2^8) inverter.
module xc_aessub_multi (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_data,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_operand;
  logic        r_enc;
  logic [1:0]  r_cnt;
  logic [31:0] r_result;
  logic [7:0]  w_byteIn;
  logic [7:0]  w_invIn;
  logic [7:0]  w_inv;
  logic [7:0]  w_sbOut;
  logic        w_unused;

  assign w_unused = ^{rs1[31:16], rs2[15:0]};

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] invAffine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    w_byteIn = r_operand[7:0];
    case (r_cnt)
      2'd0: w_byteIn = r_operand[7:0];
      2'd1: w_byteIn = r_operand[15:8];
      2'd2: w_byteIn = r_operand[23:16];
      2'd3: w_byteIn = r_operand[31:24];
      default: w_byteIn = r_operand[7:0];
    endcase
  end

  // Forward path: inverse then affine; inverse path: inverse-affine then inverse.
  assign w_invIn = r_enc ? w_byteIn : invAffine(w_byteIn);
  assign w_inv   = gfInv(w_invIn);
  assign w_sbOut = r_enc ? affine(w_inv) : w_inv;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (valid) w_stateNext = BUSY;
      BUSY: begin
        if (!valid)             w_stateNext = IDLE;
        else if (r_cnt == 2'd3) w_stateNext = DONE;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (flush) w_stateNext = IDLE;
  end

  // Dropping valid in BUSY aborts before the current byte is written.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_operand <= 32'h0;
      r_enc     <= 1'b0;
      r_result  <= 32'h0;
    end else begin
      r_state <= w_stateNext;
      if (flush) begin
        r_cnt    <= 2'd0;
        r_result <= flush_data;
      end else if (r_state == IDLE && valid) begin
        r_operand <= {rs2[31:16], rs1[15:0]};
        r_enc     <= enc;
        r_cnt     <= 2'd0;
      end else if (r_state == BUSY && valid) begin
        r_result[8*r_cnt +: 8] <= w_sbOut;
        r_cnt                  <= r_cnt + 2'd1;
      end
    end
  end

  assign ready  = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_xc_aessub_multi.sv
// Scoreboard bench for xc_aessub_multi: expected words are queued when an
// operation is driven and compared when ready pulses.
module tb_xc_aessub_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_data;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        ready;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];
  logic [7:0]  sbox [256];
  logic [7:0]  isbox[256];

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  xc_aessub_multi dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .flush_data (flush_data),
    .valid      (valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .enc        (enc),
    .ready      (ready),
    .result     (result)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic e);
    logic [7:0] by[4];
    logic [31:0] r;
    by[0] = a[7:0];
    by[1] = a[15:8];
    by[2] = b[23:16];
    by[3] = b[31:24];
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = e ? sbox[by[i]] : isbox[by[i]];
    return r;
  endfunction

  task automatic driveOp(input logic [31:0] a, input logic [31:0] b, input logic e);
    valid = 1'b1;
    rs1   = a;
    rs2   = b;
    enc   = e;
    expQ.push_back(model(a, b, e));
  endtask

  task automatic waitReady(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!ready && cyc < 20);
  endtask

  task automatic checkDone(input string name, input int cyc, input int expCyc);
    logic [31:0] exp;
    checks++;
    if (cyc !== expCyc) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, cyc, expCyc);
    end
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
    checks++;
    if (result !== exp) begin
      errors++;
      $display("[TB] FAIL %s result: got %h, expected %h", name, result, exp);
    end
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b, input logic e);
    int cyc;
    @(negedge clock);
    driveOp(a, b, e);
    waitReady(cyc);
    checkDone(name, cyc, 5);
    valid = 1'b0;
  endtask

  task automatic countReady(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (ready) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d ready pulses, expected 0", name, seen);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b1; flush_data = 32'hA5A5A5A5; valid = 1'b1;
    rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1;
    repeat (2) @(negedge clock);
    checkWord("reset result", result, 32'h0);
    checkWord("reset ready", {31'h0, ready}, 32'h0);
    reset = 1'b0; flush = 1'b0; valid = 1'b0;
    countReady("reset idle", 6);
  endtask

  task automatic test_encrypt;
    runOp("enc vector", 32'hDEAD0100, 32'hFF53BEEF, 1'b1);
    @(negedge clock);
    checkWord("ready one cycle", {31'h0, ready}, 32'h0);
    checkWord("result holds in idle", result, 32'h16ED7C63);
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clock);
    driveOp(32'h00007C63, 32'h16ED0000, 1'b0);
    waitReady(cyc);
    checkDone("b2b first", cyc, 5);
    driveOp(32'h12345678, 32'h9ABCDEF0, 1'b1);
    waitReady(cyc);
    checkDone("b2b second", cyc, 6);
    valid = 1'b0;
  endtask

  task automatic test_operand_stability;
    int cyc;
    @(negedge clock);
    driveOp(32'h0000C0FE, 32'hBA5E0000, 1'b1);
    @(negedge clock);
    rs1 = 32'hFFFFFFFF; rs2 = 32'h00000000; enc = 1'b0;
    waitReady(cyc);
    checkDone("operand stability", cyc, 4);
    valid = 1'b0;
  endtask

  task automatic test_abort;
    @(negedge clock);
    valid = 1'b1; rs1 = 32'h00001122; rs2 = 32'h33440000; enc = 1'b1;
    repeat (2) @(negedge clock);
    valid = 1'b0;
    countReady("abort no ready", 8);
    runOp("after abort", 32'h0000ABCD, 32'hEF010000, 1'b1);
  endtask

  task automatic test_flush;
    int cyc;
    @(negedge clock);
    valid = 1'b1; rs1 = 32'h00005566; rs2 = 32'h77880000; enc = 1'b1;
    repeat (2) @(negedge clock);
    flush = 1'b1; flush_data = 32'hA5A5A5A5;
    @(negedge clock);
    checkWord("flush busy result", result, 32'hA5A5A5A5);
    checkWord("flush busy ready", {31'h0, ready}, 32'h0);
    flush = 1'b0; valid = 1'b0;
    countReady("flush busy no ready", 6);
    checkWord("flush result holds", result, 32'hA5A5A5A5);
    runOp("before idle flush", 32'h00000102, 32'h03040000, 1'b0);
    @(negedge clock);
    valid = 1'b1; rs1 = 32'h0000F00D; rs2 = 32'hCAFE0000; enc = 1'b1;
    flush = 1'b1; flush_data = 32'hA5A5A5A5;
    @(negedge clock);
    checkWord("flush idle result", result, 32'hA5A5A5A5);
    checkWord("flush idle ready", {31'h0, ready}, 32'h0);
    flush = 1'b0;
    expQ.push_back(model(32'h0000F00D, 32'hCAFE0000, 1'b1));
    waitReady(cyc);
    checkDone("after idle flush", cyc, 5);
    valid = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    @(negedge clock);
    valid = 1'b1; rs1 = 32'h00009999; rs2 = 32'h88880000; enc = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1; flush = 1'b1; flush_data = 32'h5A5A5A5A;
    @(negedge clock);
    checkWord("mid reset result", result, 32'h0);
    checkWord("mid reset ready", {31'h0, ready}, 32'h0);
    reset = 1'b0; flush = 1'b0; valid = 1'b0;
    countReady("mid reset no ready", 6);
    runOp("after mid reset", 32'hDEAD0100, 32'hFF53BEEF, 1'b1);
  endtask

  task automatic test_sweep;
    logic [31:0] a, b, base;
    for (int lane = 0; lane < 4; lane++) begin
      for (int x = 0; x < 256; x++) begin
        for (int k = 0; k < 3; k++) begin
          base = $urandom;
          a = {16'h0, base[15:0]};
          b = {base[31:16], 16'h0};
          case (lane)
            0: a[7:0]   = (k == 2) ? sbox[x] : 8'(x);
            1: a[15:8]  = (k == 2) ? sbox[x] : 8'(x);
            2: b[23:16] = (k == 2) ? sbox[x] : 8'(x);
            default: b[31:24] = (k == 2) ? sbox[x] : 8'(x);
          endcase
          runOp("sweep", a, b, (k == 0));
          if (k == 2) checkWord("sweep roundtrip", 32'(result[8*lane +: 8]), 32'(x));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sbox[i] = SBOX_HEX[2047 - 8*i -: 8];
      isbox[SBOX_HEX[2047 - 8*i -: 8]] = 8'(i);
    end
    test_reset;
    test_encrypt;
    test_back_to_back;
    test_operand_stability;
    test_abort;
    test_flush;
    test_reset_mid_busy;
    test_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
